// File: rtl/comp_bsearch.sv
// rtl/comp_bsearch.sv - binary-search controller driving a magnitude comparator B operand
module comp_bsearch #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [3:0]                    cmp_r,
    output logic [WIDTH-1:0]              guess,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [WIDTH-1:0]              found,
    output logic [$clog2(WIDTH+2)-1:0]    steps
);
    localparam int SW = $clog2(WIDTH + 2);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]    MAX_STEPS   = SW'(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_WAIT   = CW'(SETTLE - 1);
    localparam logic [WIDTH:0]   FULL_HI     = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] FIRST_GUESS = FULL_HI[WIDTH:1];

    typedef enum logic [1:0] {IDLE, PROBE, DONE, ERR} state_t;

    state_t             state_q, state_d;
    logic [WIDTH:0]     lo_q, lo_d, hi_q, hi_d;
    logic [CW-1:0]      wait_q, wait_d;
    logic [WIDTH-1:0]   guess_q, guess_d;
    logic [WIDTH-1:0]   found_q, found_d;
    logic [SW-1:0]      steps_q, steps_d;

    // lo/hi carry one extra bit so guess+1 past the top and guess-1 below zero stay representable
    logic [WIDTH:0]     guess_ext, lo_inc, hi_dec;
    logic [SW-1:0]      steps_inc;
    logic               cmp_unused;

    assign cmp_unused = cmp_r[3];
    assign guess_ext  = {1'b0, guess_q};
    assign lo_inc     = guess_ext + (WIDTH+1)'(1);
    assign hi_dec     = guess_ext - (WIDTH+1)'(1);
    assign steps_inc  = steps_q + 1'b1;

    // Next-state: start handling, settle wait, and comparator result decode
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        wait_d  = wait_q;
        guess_d = guess_q;
        found_d = found_q;
        steps_d = steps_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    lo_d    = '0;
                    hi_d    = FULL_HI;
                    guess_d = FIRST_GUESS;
                    wait_d  = '0;
                    steps_d = '0;
                    state_d = PROBE;
                end
            end
            PROBE: begin
                if (wait_q != LAST_WAIT) begin
                    wait_d = wait_q + 1'b1;
                end else begin
                    wait_d  = '0;
                    steps_d = steps_inc;
                    case (cmp_r[2:0])
                        3'b010: begin
                            found_d = guess_q;
                            state_d = DONE;
                        end
                        3'b100: begin
                            lo_d = lo_inc;
                            if (lo_inc > hi_q || steps_inc == MAX_STEPS)
                                state_d = ERR;
                            else
                                guess_d = WIDTH'((lo_inc + hi_q) >> 1);
                        end
                        3'b001: begin
                            if (guess_q == '0 || lo_q > hi_dec || steps_inc == MAX_STEPS) begin
                                state_d = ERR;
                            end else begin
                                hi_d    = hi_dec;
                                guess_d = WIDTH'((lo_q + hi_dec) >> 1);
                            end
                        end
                        default: state_d = ERR;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            wait_q  <= '0;
            guess_q <= '0;
            found_q <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            wait_q  <= wait_d;
            guess_q <= guess_d;
            found_q <= found_d;
            steps_q <= steps_d;
        end
    end

    assign guess = guess_q;
    assign busy  = (state_q == PROBE);
    assign done  = (state_q == DONE);
    assign err   = (state_q == ERR);
    assign found = found_q;
    assign steps = steps_q;
endmodule

// File: tb/tb_comp_bsearch.sv
// tb/tb_comp_bsearch.sv - scoreboard bench for comp_bsearch
module tb_comp_bsearch;
    logic       clk = 1'b0;
    logic       rst, start, start3;
    logic [3:0] cmp_r, cmp3;
    logic [3:0] guess, found, guess3, found3;
    logic       busy, done, err, busy3, done3, err3;
    logic [2:0] steps, steps3;
    logic [3:0] t_val, t3;
    logic [1:0] mode;
    bit         gchk_en;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       done;
        logic       err;
        logic [3:0] found;
        logic [2:0] steps;
        bit         chk_found;
    } res_t;

    res_t       exp_q[$];
    logic [3:0] gexp_q[$];
    logic [3:0] g3_q[$];

    always #5 clk = ~clk;

    assign cmp_r = (mode == 2'd2) ? 4'b0110 :
                   (mode == 2'd1) ? 4'b0100 :
                   {1'b0, t_val > guess, t_val == guess, t_val < guess};
    assign cmp3  = {1'b0, t3 > guess3, t3 == guess3, t3 < guess3};

    comp_bsearch #(.WIDTH(4), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .cmp_r(cmp_r), .guess(guess),
        .busy(busy), .done(done), .err(err), .found(found), .steps(steps)
    );

    comp_bsearch #(.WIDTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .cmp_r(cmp3), .guess(guess3),
        .busy(busy3), .done(done3), .err(err3), .found(found3), .steps(steps3)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_res(input logic d, input logic e, input logic [3:0] f,
                            input logic [2:0] s, input bit cf);
        res_t r;
        r.done = d; r.err = e; r.found = f; r.steps = s; r.chk_found = cf;
        exp_q.push_back(r);
    endtask

    task automatic run(input logic [3:0] t, input logic [1:0] m, input int exp_lat, input bit extra);
        int n;
        t_val = t;
        mode  = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (busy && n < 60) begin
            if (extra && n == 2) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check("latency", n, exp_lat);
    endtask

    // Main monitor: checks each new guess and the outcome when a search ends
    logic       busy_prev = 1'b0;
    logic [3:0] guess_prev = 4'd0;
    always @(negedge clk) begin
        if (busy && (!busy_prev || guess != guess_prev) && gchk_en) begin
            if (gexp_q.size() == 0) begin
                check("unexpected_guess", guess, 99);
            end else begin
                check("guess_seq", guess, gexp_q.pop_front());
            end
        end
        if (busy_prev && !busy && (done || err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", done, 99);
            end else begin
                res_t r;
                r = exp_q.pop_front();
                check("res_done", done, r.done);
                check("res_err", err, r.err);
                check("res_steps", steps, r.steps);
                if (r.chk_found) check("res_found", found, r.found);
            end
        end
        busy_prev  = busy;
        guess_prev = guess;
    end

    // SETTLE=3 monitor: one expected guess per busy cycle
    always @(negedge clk) begin
        if (busy3) begin
            if (g3_q.size() == 0) check("unexpected_guess3", guess3, 99);
            else                  check("guess3_hold", guess3, g3_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int sw_steps[16] = '{4, 3, 4, 2, 4, 3, 4, 1, 4, 3, 4, 2, 4, 3, 4, 5};
        logic [3:0] g3[4] = '{4'd7, 4'd3, 4'd5, 4'd4};
        int n;
        rst = 1'b1; start = 1'b0; start3 = 1'b0; t_val = 4'd0; t3 = 4'd4;
        mode = 2'd0; gchk_en = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("rst_guess", guess, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_found", found, 0);
        check("rst_steps", steps, 0);

        gexp_q = {gexp_q, 4'd7};
        push_res(1, 0, 7, 1, 1);
        run(4'd7, 2'd0, 2, 0);

        gexp_q = {gexp_q, 4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        push_res(1, 0, 15, 5, 1);
        run(4'd15, 2'd0, 6, 1);

        gexp_q = {gexp_q, 4'd7, 4'd3, 4'd1, 4'd0};
        push_res(1, 0, 0, 4, 1);
        run(4'd0, 2'd0, 5, 0);

        gexp_q = {gexp_q, 4'd7};
        push_res(0, 1, 0, 1, 0);
        run(4'd0, 2'd2, 2, 0);

        gexp_q = {gexp_q, 4'd7, 4'd11, 4'd9};
        push_res(1, 0, 9, 3, 1);
        run(4'd9, 2'd0, 4, 0);

        gexp_q = {gexp_q, 4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        push_res(0, 1, 0, 5, 0);
        run(4'd0, 2'd1, 6, 0);

        gexp_q = {gexp_q, 4'd7, 4'd11};
        t_val = 4'd15; mode = 2'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (guess != 4'd11 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_11", guess, 11);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_guess", guess, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        check("abort_found", found, 0);
        check("abort_steps", steps, 0);

        gchk_en = 1'b0;
        for (int t = 0; t < 16; t++) begin
            push_res(1, 0, 4'(t), 3'(sw_steps[t]), 1);
            run(4'(t), 2'd0, sw_steps[t] + 1, 0);
        end

        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 3; k++) g3_q.push_back(g3[i]);
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        n = 1;
        while (!done3 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("settle3_latency", n, 13);
        check("settle3_found", found3, 4);
        check("settle3_steps", steps3, 4);
        check("settle3_err", err3, 0);

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_empty", exp_q.size(), 0);
        check("gexp_q_empty", gexp_q.size(), 0);
        check("g3_q_empty", g3_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/comp_bsearch.md
Name: comp_bsearch

Overview:
- Sequential binary-search controller that sits around the 4-bit magnitude comparator stage.
- Drives the comparator's B operand (guess) and consumes its 4-bit result vector (bit2 = A>B, bit1 = A==B, bit0 = A<B, bit3 unused).
- Finds the unknown value on the comparator's A input in at most WIDTH+1 probes.
- Reports the found value, the probe count, and an error flag if the comparator result is inconsistent.

Parameters:
- WIDTH, 4: operand width; search range is 0 .. 2^WIDTH-1.
- SETTLE, 1: cycles each guess is held before the comparator result is sampled (legal range >=1).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a search.
- cmp_r  input  4  comparator result; bit2 = A>B, bit1 = A==B, bit0 = A<B; bit3 ignored.
- guess  output  WIDTH  registered value driven to comparator B input.
- busy  output  1  high while a search is in progress.
- done  output  1  high from a successful search until the next start or rst.
- err  output  1  high from a failed search until the next start or rst.
- found  output  WIDTH  matched value; valid while done=1.
- steps  output  clog2(WIDTH+2)  number of probes taken (3 bits at default).

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; guess=0, busy=0, done=0, err=0, found=0, steps=0; lo/hi cleared. Reset has priority over all other inputs and aborts any search in progress.
- Internal registers: lo, hi are WIDTH+1 bits wide to absorb the 2^WIDTH overflow and the -1 underflow; wait counter for SETTLE.
- States:
  - IDLE: start=1 -> lo=0, hi=2^WIDTH-1, guess=(lo+hi)>>1 (7 at default), steps=0, done=0, err=0, busy=1 -> PROBE.
  - PROBE: guess held for SETTLE cycles. cmp_r is sampled on the edge that ends the SETTLE-th cycle; steps increments on that edge. Decode cmp_r[2:0]:
    - 3'b010 (eq): found=guess, done=1, busy=0 -> DONE.
    - 3'b100 (gt): lo=guess+1; if new lo>hi -> ERR, else guess=(lo+hi)>>1, restart wait -> PROBE.
    - 3'b001 (lt): if guess==0 -> ERR; else hi=guess-1; if lo>new hi -> ERR, else new guess -> PROBE.
    - Any other pattern (not one-hot, including 000): err=1, busy=0 -> ERR.
    - If steps would exceed WIDTH+1 without eq: ERR.
  - DONE / ERR: outputs held. start=1 behaves as start in IDLE; otherwise stay.
- start while busy=1 is ignored.
- guess, found, and steps stay stable (no glitches) between updates.
- Latency: first guess is valid the cycle after start. Each probe takes SETTLE cycles. done/err rise on the sampling edge of the last probe. Total cycles from start to done = probes × SETTLE + 1.
- Arithmetic: midpoint is floor((lo+hi)/2), computed in WIDTH+1 bits and truncated to WIDTH when driven on guess.

Test Plan:
- Bench model: cmp_r = {0, T>guess, T==guess, T<guess}.
- T=7, SETTLE=1: start -> guess 7 next cycle; done=1 one cycle later, found=7, steps=1.
- T=15, SETTLE=1: guess sequence 7, 11, 13, 14, 15 -> done, found=15, steps=5. T=0: guess sequence 7, 3, 1, 0 -> steps=4. Sweep all T=0..15: always done, found=T, steps<=5.
- Force cmp_r=4'b0110 on the first probe -> err=1, busy=0, done=0. Then start with a correct model (T=9) -> err clears, done=1, found=9.
- Inconsistent model (always gt): guess 7, 11, 13, 14, 15, then lo=16>hi -> err=1, steps=5.
- rst asserted mid-search (after guess=11) -> next cycle all outputs 0, state IDLE. start pulsed while busy -> no restart; guess sequence unchanged.
- SETTLE=3, T=4: each guess (7, 3, 5, 4) held exactly 3 cycles; done asserts 13 cycles after the start edge.
